// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI-lite master engine
// between N requesters; a watchdog aborts commands the master never finishes.
module axi_lite_cmd_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 255
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_write,
   input  logic [N*32-1:0] req_addr,
   input  logic [N*32-1:0] req_wdata,
   input  logic [N*4-1:0]  req_wstrb,
   output logic [N-1:0]    req_grant,
   output logic [N-1:0]    req_done,
   output logic [31:0]     req_rdata,
   output logic [1:0]      req_resp,
   output logic            busy,
   output logic            m_valid,
   output logic            m_read_valid,
   output logic [31:0]     m_aw_addr,
   output logic [31:0]     m_ar_addr,
   output logic [31:0]     m_w_data,
   output logic [3:0]      m_w_strb,
   input  logic            m_ready,
   input  logic [1:0]      m_bresp,
   input  logic            m_rdone,
   input  logic [31:0]     m_rdata,
   input  logic [1:0]      m_rresp
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] last_q;
   logic [IW-1:0] win;
   logic          any;
   logic [15:0]   wd_q;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic          cpl;
   logic          expire;

   assign m_aw_addr = addr_q;
   assign m_ar_addr = addr_q;

   // Only the completion strobe matching the latched direction counts.
   assign cpl    = wr_q ? m_ready : m_rdone;
   assign expire = (wd_q == 16'(TIMEOUT - 1));

   // Search starts one past the previous winner.
   always_comb begin
      int            idx;
      logic [IW-1:0] cand;
      idx  = 0;
      cand = '0;
      win  = last_q;
      any  = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = int'(last_q) + i;
         if (idx >= N)
            idx = idx - N;
         cand = IW'(idx);
         if (!any && req_valid[cand]) begin
            any = 1'b1;
            win = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cpl || expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         last_q       <= IW'(N - 1);
         wd_q         <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         m_w_data     <= '0;
         m_w_strb     <= '0;
         m_valid      <= 1'b0;
         m_read_valid <= 1'b0;
         req_grant    <= '0;
         req_done     <= '0;
         req_rdata    <= '0;
         req_resp     <= '0;
         busy         <= 1'b0;
      end else begin
         req_grant    <= '0;
         req_done     <= '0;
         m_valid      <= 1'b0;
         m_read_valid <= 1'b0;
         busy         <= (state_d != IDLE);
         if (state_q == IDLE && any) begin
            last_q       <= win;
            req_grant    <= N'(1) << win;
            wr_q         <= req_write[win];
            addr_q       <= req_addr[32*win +: 32];
            m_w_data     <= req_wdata[32*win +: 32];
            m_w_strb     <= req_wstrb[4*win +: 4];
            m_valid      <= req_write[win];
            m_read_valid <= ~req_write[win];
         end
         if (state_q == ISSUE)
            wd_q <= '0;
         if (state_q == WAIT) begin
            if (cpl) begin
               req_done  <= N'(1) << last_q;
               req_resp  <= wr_q ? m_bresp : m_rresp;
               req_rdata <= wr_q ? 32'd0 : m_rdata;
            end else if (expire) begin
               req_done  <= N'(1) << last_q;
               req_resp  <= 2'b11;
               req_rdata <= '0;
            end else begin
               wd_q <= wd_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed bench for axi_lite_cmd_arbiter: stimulus queues expected grants,
// issues and completions; a negedge monitor pops and compares them.
module tb_axi_lite_cmd_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic [N-1:0]    req_valid, req_write;
   logic [N*32-1:0] req_addr, req_wdata;
   logic [N*4-1:0]  req_wstrb;
   logic [N-1:0]    req_grant, req_done;
   logic [31:0]     req_rdata;
   logic [1:0]      req_resp;
   logic            busy, m_valid, m_read_valid;
   logic [31:0]     m_aw_addr, m_ar_addr, m_w_data;
   logic [3:0]      m_w_strb;
   logic            m_ready, m_rdone;
   logic [1:0]      m_bresp, m_rresp;
   logic [31:0]     m_rdata;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } iss_t;

   typedef struct {
      logic [N-1:0] id;
      logic [1:0]   r;
      logic [31:0]  rd;
   } done_t;

   logic [N-1:0] q_grant[$];
   iss_t         q_iss[$];
   done_t        q_done[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int outst = 0;
   int ndone = 0;

   axi_lite_cmd_arbiter #(.N(N), .TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_grant(req_grant), .req_done(req_done),
      .req_rdata(req_rdata), .req_resp(req_resp), .busy(busy),
      .m_valid(m_valid), .m_read_valid(m_read_valid),
      .m_aw_addr(m_aw_addr), .m_ar_addr(m_ar_addr),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_ready(m_ready), .m_bresp(m_bresp),
      .m_rdone(m_rdone), .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: got an unexpected or missing event, expected none", nm);
   endtask

   initial forever begin
      @(negedge ACLK);
      if (!ARESET) begin
         outst = 0;
      end else begin
         if (req_grant != '0) begin
            if (q_grant.size() == 0) flag("grant_unexpected");
            else chk("grant", 64'(req_grant), 64'(q_grant.pop_front()));
         end
         if (m_valid || m_read_valid) begin
            iss_t e;
            chk("one_outstanding", 64'(outst), 64'd0);
            outst = 1;
            if (q_iss.size() == 0) begin
               flag("issue_unexpected");
            end else begin
               e = q_iss.pop_front();
               chk("issue_dir", 64'({m_valid, m_read_valid}), 64'({e.w, ~e.w}));
               chk("issue_addr", {m_aw_addr, m_ar_addr}, {e.a, e.a});
               chk("issue_wdata", 64'({m_w_strb, m_w_data}), 64'({e.s, e.d}));
            end
         end
         if (req_done != '0) begin
            done_t e;
            outst = 0;
            ndone++;
            if (q_done.size() == 0) begin
               flag("done_unexpected");
            end else begin
               e = q_done.pop_front();
               chk("done", 64'({req_done, req_resp, req_rdata}), 64'({e.id, e.r, e.rd}));
            end
         end
      end
   end

   task automatic expect_txn(input int id, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] r, input logic [31:0] rd);
      iss_t  ei;
      done_t ed;
      ei.w  = w;
      ei.a  = a;
      ei.d  = d;
      ei.s  = s;
      ed.id = N'(1) << id;
      ed.r  = r;
      ed.rd = rd;
      q_grant.push_back(N'(1) << id);
      q_iss.push_back(ei);
      q_done.push_back(ed);
   endtask

   task automatic put(input int id, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      req_write[id]          = w;
      req_addr[32*id +: 32]  = a;
      req_wdata[32*id +: 32] = d;
      req_wstrb[4*id +: 4]   = s;
      req_valid[id]          = 1'b1;
   endtask

   task automatic wait_grant(input int id);
      int n = 0;
      while (!req_grant[id] && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      if (n >= 50) flag("grant_wait");
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_done(output int t);
      int n = 0;
      while (req_done == '0 && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      if (n >= 50) flag("done_wait");
      t = cyc;
   endtask

   // Master model: completes d cycles after the issue pulse is seen.
   task automatic serve(input int d, input bit stray, input bit drop, input bit clr,
                        input logic [1:0] rsp, input logic [31:0] rd,
                        output int ti, output int tc);
      int   n = 0;
      logic w;
      while (!(m_valid || m_read_valid) && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      ti = cyc;
      tc = cyc;
      if (n >= 50) begin
         flag("issue_wait");
         return;
      end
      if (clr) req_valid = '0;
      w = m_valid;
      for (int k = 1; k <= d; k++) begin
         @(negedge ACLK);
         m_ready = 1'b0;
         m_rdone = 1'b0;
         if (stray && k == d - 2) begin
            if (w) begin
               m_rdone = 1'b1;
               m_rresp = 2'b01;
               m_rdata = 32'hBAD0_BAD0;
            end else begin
               m_ready = 1'b1;
               m_bresp = 2'b01;
            end
         end
      end
      if (drop) return;
      if (w) begin
         m_ready = 1'b1;
         m_bresp = rsp;
      end else begin
         m_rdone = 1'b1;
         m_rresp = rsp;
         m_rdata = rd;
      end
      tc = cyc;
      @(negedge ACLK);
      m_ready = 1'b0;
      m_rdone = 1'b0;
      m_bresp = '0;
      m_rresp = '0;
      m_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int ti, tc, td, tprev, nd;
      ARESET    = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      m_ready   = 1'b0;
      m_rdone   = 1'b0;
      m_bresp   = '0;
      m_rresp   = '0;
      m_rdata   = '0;
      tprev     = 0;
      repeat (3) @(negedge ACLK);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ctrl", 64'({req_grant, req_done, req_resp, m_valid, m_read_valid}), 64'd0);
      chk("reset_data", {req_rdata, m_aw_addr}, 64'd0);
      ARESET = 1'b1;
      @(negedge ACLK);

      // single write
      expect_txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0);
      put(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      wait_grant(1);
      serve(3, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, ti, tc);
      wait_done(td);
      chk("wr_done_latency", 64'(td - tc), 64'd1);
      chk("wr_issue_to_done", 64'(td - ti), 64'd4);

      // single read
      expect_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 2'b00, 32'h1234_5678);
      put(2, 1'b0, 32'h20, 32'h0, 4'h0);
      wait_grant(2);
      serve(2, 1'b0, 1'b0, 1'b0, 2'b00, 32'h1234_5678, ti, tc);
      wait_done(td);
      chk("rd_done_latency", 64'(td - tc), 64'd1);
      @(negedge ACLK);
      chk("rd_idle_busy", 64'(busy), 64'd0);

      // reset while a read waits on the master
      q_grant.push_back(4'b0100);
      begin
         iss_t ei;
         ei.w = 1'b0;
         ei.a = 32'h30;
         ei.d = 32'h0;
         ei.s = 4'h0;
         q_iss.push_back(ei);
      end
      put(2, 1'b0, 32'h30, 32'h0, 4'h0);
      wait_grant(2);
      serve(2, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, ti, tc);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      ARESET = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ctrl", 64'({req_grant, req_done, req_resp, m_valid, m_read_valid}), 64'd0);
      chk("rst_rdata", 64'(req_rdata), 64'd0);
      chk("rst_maddr", {m_aw_addr, m_ar_addr}, 64'd0);
      chk("rst_mdata", 64'({m_w_strb, m_w_data}), 64'd0);
      @(negedge ACLK);
      m_rdone = 1'b1;
      m_rdata = 32'h5555_AAAA;
      @(negedge ACLK);
      m_rdone = 1'b0;
      ARESET  = 1'b1;
      @(negedge ACLK);
      m_rdone = 1'b1;
      @(negedge ACLK);
      m_rdone = 1'b0;
      m_rdata = '0;
      @(negedge ACLK);
      chk("post_rst_stray_busy", 64'(busy), 64'd0);
      expect_txn(0, 1'b1, 32'h60, 32'h1111_1111, 4'hF, 2'b00, 32'h0);
      expect_txn(3, 1'b0, 32'h70, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D);
      put(3, 1'b0, 32'h70, 32'h0, 4'h0);
      put(0, 1'b1, 32'h60, 32'h1111_1111, 4'hF);
      wait_grant(0);
      serve(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, ti, tc);
      wait_done(td);
      wait_grant(3);
      serve(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'hCAFE_F00D, ti, tc);
      wait_done(td);

      // contention: all four hold requests, grants rotate 0..3 twice
      for (int j = 0; j < 8; j++)
         expect_txn(j % 4, 1'b1, 32'h100 * (j % 4 + 1), 32'hC0DE_0000 + (j % 4),
                    4'((j % 4) + 1), 2'b01, 32'h0);
      @(negedge ACLK);
      for (int i = 0; i < 4; i++)
         put(i, 1'b1, 32'h100 * (i + 1), 32'hC0DE_0000 + i, 4'(i + 1));
      for (int j = 0; j < 8; j++) begin
         serve(1, 1'b0, 1'b0, (j == 7), 2'b01, 32'h0, ti, tc);
         if (j > 0) chk("rr_turnaround", 64'(ti - tprev), 64'd4);
         tprev = ti;
      end
      wait_done(td);
      @(negedge ACLK);
      chk("rr_idle_busy", 64'(busy), 64'd0);

      // watchdog expiry, then a late completion
      expect_txn(1, 1'b1, 32'h40, 32'h55AA_55AA, 4'hC, 2'b11, 32'h0);
      put(1, 1'b1, 32'h40, 32'h55AA_55AA, 4'hC);
      wait_grant(1);
      serve(0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, ti, tc);
      wait_done(td);
      chk("timeout_latency", 64'(td - ti), 64'(TO + 1));
      @(negedge ACLK);
      nd      = ndone;
      m_ready = 1'b1;
      m_bresp = 2'b00;
      @(negedge ACLK);
      m_ready = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("late_ready_busy", 64'(busy), 64'd0);
      chk("late_ready_no_done", 64'(ndone), 64'(nd));

      // write sees a stray read strobe before its real completion
      expect_txn(3, 1'b1, 32'h50, 32'hA5A5_5A5A, 4'h3, 2'b10, 32'h0);
      put(3, 1'b1, 32'h50, 32'hA5A5_5A5A, 4'h3);
      wait_grant(3);
      serve(4, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0, ti, tc);
      wait_done(td);
      chk("filter_latency", 64'(td - tc), 64'd1);

      repeat (5) @(negedge ACLK);
      chk("queues_empty", 64'(q_grant.size() + q_iss.size() + q_done.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
